bcd_display_scan: RTL
=====================

# bcd_display_scan

- Drives the board's multiplexed 7-segment display from the packed BCD digits produced by the clock's counters.
- Consumes the counter outputs: samples the whole digit vector once per frame, decodes each digit and scans the digit enables one at a time.
- Inserts a dead time between digits to suppress ghosting.
- Sits between the time-keeping counters and the display pins.

## Interface
- NUM_DIGITS, 3, number of digits scanned; digit 0 is least significant.
- DWELL_CYCLES, 1000, i_clk cycles each digit is driven; must be ≥1.
- BLANK_CYCLES, 16, i_clk cycles with all digits off between digits; must be ≥1.
- SEG_ACTIVE_LOW, 1, 1 = o_seg/o_dp active-low, 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = o_an active-low, 0 = active-high.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ena  in  1  display enable; 0 forces all digits off, but scanning continues.
- i_bcd  in  4*NUM_DIGITS  packed BCD; digit k is i_bcd[4k+3:4k].
- i_dp  in  NUM_DIGITS  decimal point per digit.
- i_lzb  in  1  leading-zero blanking enable.
- o_seg  out  7  segments, bit0=a … bit6=g.
- o_dp  out  1  decimal point of the driven digit.
- o_an  out  NUM_DIGITS  digit enables, one-hot when driving.
- o_frame  out  1  one-cycle pulse on the cycle the snapshot is taken.

## Operation
- FSM with two states and a down-counter cnt.
  - BLANK: lasts BLANK_CYCLES cycles, then moves to DRIVE with the same idx.
  - DRIVE: lasts DWELL_CYCLES cycles, then moves to BLANK with idx+1; idx wraps from NUM_DIGITS-1 to 0.
- Snapshot: on the first cycle of BLANK with idx=0, register i_bcd and i_dp into snap_bcd/snap_dp and pulse o_frame.
  - All decoding uses the snapshot only, so no digit tears mid-frame.
- Decode, internal active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values A–F are not valid BCD and display a dash (40).
- Leading-zero blanking, when i_lzb=1:
  - Digit k>0 is blanked if its snapshot value and every higher digit's value are 0.
  - Digit 0 is never blanked.
  - A blanked digit gets segments off and o_dp from snap_dp; its enable is still asserted.
- Output values:
  - In DRIVE with i_ena=1: o_an has only bit idx active, and o_seg/o_dp carry digit idx.
  - In BLANK, or when i_ena=0: o_an all inactive, o_seg and o_dp inactive.
- Polarity: SEG_ACTIVE_LOW inverts o_seg and o_dp; AN_ACTIVE_LOW inverts o_an.
- Reset, while i_reset is high:
  - state=BLANK, idx=0, cnt loaded for the first BLANK, snapshot cleared to 0.
  - o_an all inactive, o_seg/o_dp inactive, o_frame=0.
  - Reset mid-DRIVE aborts the digit at the next edge; no partial dwell is resumed.

## Timing
- All outputs are registered and are computed from next-state, so:
  - o_an is active for exactly DWELL_CYCLES consecutive cycles per digit.
  - o_an is inactive for exactly BLANK_CYCLES cycles between digits.
- o_seg, o_dp and o_an change on the same edge.
- Digit period is BLANK_CYCLES+DWELL_CYCLES; frame period is NUM_DIGITS times that.
- After reset deasserts:
  - o_frame pulses on the first clock edge with i_reset low.
  - Digit 0 is first driven BLANK_CYCLES cycles after that edge.
- i_bcd/i_dp changes outside the snapshot cycle have no visible effect until the next frame; one snapshot per frame.
- i_ena is applied combinationally into the output register, so the outputs respond one cycle after i_ena changes.
- cnt width is $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1); no overflow is possible.

## Structure
- Shared package holds the segment pattern constants (SEG_0…SEG_9, SEG_DASH, SEG_OFF) and the FSM state enum.
- Sub-module bcd_to_seg7 is purely combinational: a 4-bit nibble in, active-high gfedcba out, dash for A–F.
- The top holds the FSM, counter, snapshot registers, LZB logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=3, DWELL_CYCLES=4, BLANK_CYCLES=2 and active-low polarity unless stated.
- Reset: hold i_reset for 3 cycles, then release.
  - o_an=3'b111 and o_seg=7'h7F throughout reset.
  - o_frame pulses once at the first edge after release.
  - o_an=3'b110 for cycles 3–6 after release.
- Scan: i_bcd=12'h459, i_ena=1, i_lzb=0.
  - Sequence is 2 blank, 4×an=110 with seg=~6F, 2 blank, 4×an=101 with seg=~6D, 2 blank, 4×an=011 with seg=~66, then repeat.
  - o_frame period is 18 cycles.
- Snapshot: change i_bcd from 12'h123 to 12'h456 while digit 1 is driven.
  - Digit 2 still shows 1.
  - The next frame shows 4/5/6.
- LZB, i_lzb=1:
  - i_bcd=12'h007 → digits 2 and 1 blanked (seg=7F, enable still asserted), digit 0 shows 7.
  - i_bcd=12'h000 → digit 0 shows 0.
  - i_bcd=12'h050 → only digit 2 blanked.
- Invalid/dp: i_bcd=12'h0A0 with i_dp=3'b010 → digit 1 shows a dash (seg=~40) with o_dp=0 (lit).
- Enable/reset mid-frame:
  - i_ena=0 for 10 cycles → o_an all 1, and the scan phase after re-enable matches an uninterrupted run.
  - i_reset asserted mid-DRIVE → outputs inactive on the next edge, then restart from the reset sequence.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment patterns and FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bcd_display_scan_pkg;

    // Active-high gfedcba patterns; bit0 = segment a, bit6 = segment g.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scanner phases: all digits dark, or one digit driven.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_display_scan_seg7.sv
// BCD nibble to active-high gfedcba segment decoder; non-BCD nibbles show a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup; A-F are not valid BCD and fall through to the dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Scans packed BCD digits onto a multiplexed 7-segment display with dead time between digits.
// Latency: outputs registered from next-state; o_frame pulses on the first edge after reset release.
// Backpressure: none; i_bcd/i_dp are sampled once per frame, i_ena only gates the outputs.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ena,
    input  logic [4*NUM_DIGITS-1:0] i_bcd,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_lzb,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // cnt counts down to 0 within each phase; the reset value sits one above the first
    // BLANK value so that the first edge after release is the first BLANK cycle.
    localparam logic [CNT_W-1:0] CNT_RESET       = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_BLANK_FIRST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE_FIRST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST        = IDX_W'(NUM_DIGITS - 1);

    localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_INACT = {7{SEG_INV}};
    localparam logic                  DP_INACT  = SEG_INV;
    localparam logic [NUM_DIGITS-1:0] AN_INACT  = {NUM_DIGITS{AN_INV}};

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    take_snap;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [6:0]              dec_seg;

    // Phase sequencing: BLANK -> DRIVE on the same digit, DRIVE -> BLANK on the next digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
            if (state_q == ST_BLANK) begin
                state_d = ST_DRIVE;
                cnt_d   = CNT_DRIVE_FIRST;
            end else begin
                state_d = ST_BLANK;
                cnt_d   = CNT_BLANK_FIRST;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
        end
        // The first BLANK cycle of digit 0 opens a new frame.
        take_snap  = (state_d == ST_BLANK) && (idx_d == '0) && (cnt_d == CNT_BLANK_FIRST);
        snap_bcd_d = take_snap ? i_bcd : snap_bcd_q;
        snap_dp_d  = take_snap ? i_dp  : snap_dp_q;
    end

    // Select the digit about to be driven from the frozen snapshot, including its blanking state.
    always_comb begin
        logic all_zero;
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        all_zero   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                cur_nibble = snap_bcd_q[4*k +: 4];
                cur_dp     = snap_dp_q[k];
            end
        end
        // Walk down from the top digit; digit 0 is never a candidate for blanking.
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            all_zero = all_zero && (snap_bcd_q[4*k +: 4] == 4'd0);
            if (idx_d == IDX_W'(k)) begin
                cur_lz = all_zero;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .i_nibble (cur_nibble),
        .o_seg    (dec_seg)
    );

    // Output values for the upcoming cycle, polarity applied before registering.
    always_comb begin
        logic                  drive;
        logic [6:0]            seg_act;
        logic [NUM_DIGITS-1:0] an_act;
        drive   = (state_d == ST_DRIVE) && i_ena;
        seg_act = SEG_OFF;
        an_act  = '0;
        if (drive) begin
            seg_act = (i_lzb && cur_lz) ? SEG_OFF : dec_seg;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_act[k] = (idx_d == IDX_W'(k));
            end
        end
        seg_d   = SEG_INV ? ~seg_act : seg_act;
        dp_d    = SEG_INV ? ~(drive && cur_dp) : (drive && cur_dp);
        an_d    = AN_INV ? ~an_act : an_act;
        frame_d = take_snap;
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            cnt_q      <= CNT_RESET;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            seg_q      <= SEG_INACT;
            dp_q       <= DP_INACT;
            an_q       <= AN_INACT;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule
